// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs, word width.
package y86_pkg;

   localparam int WORD_W = 64;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;   // also the cmovXX family
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] RNONE = 4'hF;   // "no register"
   localparam logic [3:0] RRSP  = 4'h4;   // %rsp

   // True when id names a real architectural register.
   function automatic logic id_valid(input logic [3:0] id,
                                     input logic [3:0] rnone,
                                     input int         nreg);
      return (id != rnone) && (int'(id) < nreg);
   endfunction

endpackage

// File: rtl/decode_wb_64_regfile.sv
// Architectural register file: two combinational reads, two synchronous
// writes (E and M ports). When both write the same register, M wins.
module regfile_15x64
   import y86_pkg::*;
#(
   parameter int NREG = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        rd_a_id,
   input  logic [3:0]        rd_b_id,
   output logic [WORD_W-1:0] rd_a_data,
   output logic [WORD_W-1:0] rd_b_data,
   input  logic              we_e,
   input  logic [3:0]        wr_e_id,
   input  logic [WORD_W-1:0] wr_e_data,
   input  logic              we_m,
   input  logic [3:0]        wr_m_id,
   input  logic [WORD_W-1:0] wr_m_data
);

   logic [WORD_W-1:0] regs [NREG];

   // Read ports: IDs outside the register range read as zero.
   always_comb begin
      rd_a_data = '0;
      rd_b_data = '0;
      if (int'(rd_a_id) < NREG) rd_a_data = regs[rd_a_id];
      if (int'(rd_b_id) < NREG) rd_b_data = regs[rd_b_id];
   end

   // Write ports: M is assigned last so it takes priority on a collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         if (we_e && int'(wr_e_id) < NREG) regs[wr_e_id] <= wr_e_data;
         if (we_m && int'(wr_m_id) < NREG) regs[wr_m_id] <= wr_m_data;
      end
   end

endmodule

// File: rtl/decode_wb_64.sv
// Y86-64 decode and write-back stage around a 15x64 register file.
// Strobe semantics: dec_en and wb_en are single-cycle strobes with no
// back-pressure; each asserted edge performs exactly one decode / one
// write-back, and a write-back uses the IDs latched by the previous decode.
module decode_wb_64
   import y86_pkg::*;
#(
   parameter int         NREG  = 15,
   parameter logic [3:0] RNONE = y86_pkg::RNONE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dec_en,
   input  logic [3:0]        icode,
   input  logic [3:0]        rA,
   input  logic [3:0]        rB,
   input  logic              wb_en,
   input  logic              cnd,
   input  logic [WORD_W-1:0] valE,
   input  logic [WORD_W-1:0] valM,
   output logic [WORD_W-1:0] valA,
   output logic [WORD_W-1:0] valB,
   output logic [3:0]        srcA,
   output logic [3:0]        srcB,
   output logic [3:0]        dstE,
   output logic [3:0]        dstM,
   output logic              dec_err
);

   logic [3:0]        src_a_d, src_b_d, dst_e_d, dst_m_d;
   logic              err_d;
   logic [3:0]        icode_q;
   logic              we_e, we_m;
   logic [WORD_W-1:0] rf_a, rf_b, fwd_a, fwd_b;

   // Register ID selection for the instruction currently presented by fetch.
   always_comb begin
      src_a_d = RNONE;
      src_b_d = RNONE;
      dst_e_d = RNONE;
      dst_m_d = RNONE;
      err_d   = (icode > I_POPQ);
      case (icode)
         I_RRMOVQ: begin src_a_d = rA; dst_e_d = rB; end
         I_IRMOVQ: begin dst_e_d = rB; end
         I_RMMOVQ: begin src_a_d = rA; src_b_d = rB; end
         I_MRMOVQ: begin src_b_d = rB; dst_m_d = rA; end
         I_OPQ:    begin src_a_d = rA; src_b_d = rB; dst_e_d = rB; end
         I_CALL:   begin src_b_d = RRSP; dst_e_d = RRSP; end
         I_RET:    begin src_a_d = RRSP; src_b_d = RRSP; dst_e_d = RRSP; end
         I_PUSHQ:  begin src_a_d = rA; src_b_d = RRSP; dst_e_d = RRSP; end
         I_POPQ:   begin src_a_d = RRSP; src_b_d = RRSP; dst_e_d = RRSP; dst_m_d = rA; end
         default:  ;
      endcase
      if (err_d) begin
         dst_e_d = RNONE;
         dst_m_d = RNONE;
      end
   end

   // Write enables from the latched IDs; a cmov only writes when cnd is true.
   always_comb begin
      we_e = wb_en && id_valid(dstE, RNONE, NREG) && ((icode_q != I_RRMOVQ) || cnd);
      we_m = wb_en && id_valid(dstM, RNONE, NREG);
   end

   regfile_15x64 #(.NREG(NREG)) u_rf (
      .clk       (clk),
      .rst       (rst),
      .rd_a_id   (src_a_d),
      .rd_b_id   (src_b_d),
      .rd_a_data (rf_a),
      .rd_b_data (rf_b),
      .we_e      (we_e),
      .wr_e_id   (dstE),
      .wr_e_data (valE),
      .we_m      (we_m),
      .wr_m_id   (dstM),
      .wr_m_data (valM)
   );

   // Write-first bypass: a same-edge write-back is seen by the decode,
   // M before E to match the register file's collision priority.
   always_comb begin
      fwd_a = rf_a;
      fwd_b = rf_b;
      if (we_m && dstM == src_a_d)      fwd_a = valM;
      else if (we_e && dstE == src_a_d) fwd_a = valE;
      if (we_m && dstM == src_b_d)      fwd_b = valM;
      else if (we_e && dstE == src_b_d) fwd_b = valE;
   end

   // Decode latch: reset wins, otherwise capture on dec_en and hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         valA    <= '0;
         valB    <= '0;
         srcA    <= RNONE;
         srcB    <= RNONE;
         dstE    <= RNONE;
         dstM    <= RNONE;
         dec_err <= 1'b0;
         icode_q <= I_NOP;
      end else if (dec_en) begin
         valA    <= fwd_a;
         valB    <= fwd_b;
         srcA    <= src_a_d;
         srcB    <= src_b_d;
         dstE    <= dst_e_d;
         dstM    <= dst_m_d;
         dec_err <= err_d;
         icode_q <= icode;
      end
   end

endmodule

// File: doc/decode_wb_64.md
DECODE_WB_64 -- requirements
Module: decode_wb_64

Interface
REQ-001 SHALL have parameter NREG, default 15: number of architectural 64-bit registers; valid IDs are 0..NREG-1.
REQ-002 SHALL have parameter RNONE, default 4'hF: the "no register" ID.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port dec_en, input, 1: decode strobe; latches source/destination IDs and operand values.
REQ-006 SHALL have port icode, input, 4: instruction code from fetch.
REQ-007 SHALL have port rA, input, 4: register A field from fetch.
REQ-008 SHALL have port rB, input, 4: register B field from fetch.
REQ-009 SHALL have port wb_en, input, 1: write-back strobe for the previously decoded instruction.
REQ-010 SHALL have port cnd, input, 1: condition result from execute; gates the cmovXX write.
REQ-011 SHALL have port valE, input, 64: ALU result written to dstE.
REQ-012 SHALL have port valM, input, 64: memory result written to dstM.
REQ-013 SHALL have port valA, output, 64: registered operand A.
REQ-014 SHALL have port valB, output, 64: registered operand B.
REQ-015 SHALL have ports srcA, srcB, dstE, dstM, each output, 4: latched register IDs; RNONE means unused.
REQ-016 SHALL have port dec_err, output, 1: registered flag, set when icode is greater than 4'hB.

Function
REQ-017 SHALL select srcA combinationally: rA for icode 2, 4, 6, A; 4'h4 (%rsp) for icode 9, B; RNONE otherwise.
REQ-018 SHALL select srcB: rB for icode 4, 5, 6; 4'h4 for icode 8, 9, A, B; RNONE otherwise.
REQ-019 SHALL select dstE: rB for icode 2, 3, 6; 4'h4 for icode 8, 9, A, B; RNONE otherwise.
REQ-020 SHALL select dstM: rA for icode 5, B; RNONE otherwise.
REQ-021 SHALL, on a rising edge with dec_en=1, latch srcA, srcB, dstE, dstM, dec_err, valA and valB; with dec_en=0, SHALL hold all outputs.
REQ-022 SHALL drive valA/valB as 0 when the corresponding source ID is RNONE or is NREG or above.
REQ-023 SHALL, on a rising edge with wb_en=1, write valE to reg[dstE] (latched ID) and valM to reg[dstM] (latched ID).
REQ-024 SHALL write dstE for latched icode 2 only when cnd=1.
REQ-025 SHALL suppress any write whose ID is RNONE or is NREG or above.
REQ-026 SHALL, when dstE equals dstM with both valid and both written, leave valM in the register (M priority).
REQ-027 SHALL, when dec_en and wb_en are active on the same edge, compute valA/valB with write-first bypass: priority is valM match, then valE match, then register contents.
REQ-028 SHALL complete decode with 1-cycle latency: IDs and values appear on the edge following dec_en.
REQ-029 SHALL complete write-back with 1-cycle latency: a write is visible to a decode on the next edge, or on the same edge via bypass.
REQ-030 SHALL perform no writes and leave registers unchanged on invalid icode (dec_err=1 forces dstE and dstM to RNONE).

Reset
REQ-031 SHALL, on rst=1 at a rising edge, clear all NREG registers to 0.
REQ-032 SHALL reset valA/valB to 0, srcA/srcB/dstE/dstM to RNONE, and dec_err to 0.
REQ-033 SHALL give rst priority over simultaneous dec_en and wb_en: the pending write is dropped mid-operation.

Structure
REQ-034 SHALL place the icode constants (HALT=0 through POPQ=B), RNONE, RRSP=4'h4 and the 64-bit word width in shared package y86_pkg, which is also used by fetch.
REQ-035 SHALL implement register storage as sub-module regfile_15x64: two combinational read ports, two synchronous write ports, M-priority on write collision.

Verification
REQ-036 SHALL cover: irmovq (icode 3, rB=2), wb_en with valE=0x1234 -> reg2=0x1234; then opq rA=2, rB=2 -> valA=valB=0x1234.
REQ-037 SHALL cover: popq rA=3, wb_en with valE=0x100, valM=0xAB -> reg4=0x100, reg3=0xAB; for popq rA=4, reg4=0xAB.
REQ-038 SHALL cover: cmovXX rA=1, rB=5, valE=7 -> cnd=0 leaves reg5 unchanged; cnd=1 sets reg5=7.
REQ-039 SHALL cover: wb_en with dstE=6, valE=0x55 on the same edge as dec_en for rrmovq rA=6 -> valA=0x55 (bypass).
REQ-040 SHALL cover: icode 4'hC -> dec_err=1, all IDs RNONE, no register changes; icode 9 (ret) -> srcA=srcB=dstE=4, dstM=RNONE.
REQ-041 SHALL cover: rst asserted with wb_en=1 pending -> all registers 0, outputs at reset values on the next cycle.
